// File: rtl/ticket_arbiter_pkg.sv
// Shared definitions for the kiosk-to-queue producer path: default sizes,
// ticket constants, effective arbitration state and the ticket numbering rule.
package ticket_arbiter_pkg;

  localparam int DT_SZ_DEF = 4;
  localparam int KIOSK_DEF = 3;

  localparam int unsigned TICKET_FIRST = 32'd1;
  localparam int unsigned TICKET_NONE  = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_STALL = 2'd2
  } arb_state_e;

  // Sequence 1 .. 2^width-1, then back to 1; zero means "no customer" downstream.
  function automatic int unsigned next_ticket(input int unsigned cur, input int unsigned width);
    int unsigned top;
    top = (32'd1 << width) - 32'd1;
    if ((cur >= top) || (cur == TICKET_NONE)) return TICKET_FIRST;
    return cur + 32'd1;
  endfunction

endpackage

// File: rtl/ticket_arbiter_if.sv
// Kiosk request / queue-FIFO write bundle. The kiosk+FIFO side is the master,
// the arbiter is the slave.
interface ticket_arbiter_if
  import ticket_arbiter_pkg::*;
#(
  parameter int DT_SZ = DT_SZ_DEF,
  parameter int KIOSK = KIOSK_DEF
);

  // Handshake: req[i] is a single-cycle request qualified by its rt slice at clk rise;
  // each request is answered later by exactly one ack[i] (with we) or at that edge by drop[i].
  logic [KIOSK-1:0]       req;
  logic [KIOSK*DT_SZ-1:0] rt;
  logic                   full;
  logic                   we;
  logic [DT_SZ-1:0]       wn;
  logic [DT_SZ-1:0]       wt;
  logic [KIOSK-1:0]       ack;
  logic [KIOSK-1:0]       drop;
  logic [KIOSK-1:0]       pend;
  logic [DT_SZ-1:0]       nxt;
  arb_state_e             state;

  modport master (
    output req, rt, full,
    input  we, wn, wt, ack, drop, pend, nxt, state
  );

  modport slave (
    input  req, rt, full,
    output we, wn, wt, ack, drop, pend, nxt, state
  );

endinterface

// File: rtl/ticket_arbiter_rr_arbiter.sv
// Round-robin pick among pending kiosks: first set bit at or above ptr, else the
// first set bit overall (wrap). Purely combinational.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // Returns {found, index} of the lowest set bit.
  function automatic logic [IW:0] first_set(input logic [N-1:0] v);
    logic          found;
    logic [IW-1:0] pos;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && v[i]) begin
        found = 1'b1;
        pos   = IW'(i);
      end
    end
    return {found, pos};
  endfunction

  logic [N-1:0]  mask;
  logic [IW:0]   hit_masked;
  logic [IW:0]   hit_any;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    hit_masked = first_set(pend & mask);
    hit_any    = first_set(pend);
    if (hit_masked[IW]) begin
      vld = 1'b1;
      idx = hit_masked[IW-1:0];
    end else begin
      vld = hit_any[IW];
      idx = hit_any[IW-1:0];
    end
    gnt = vld ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/ticket_arbiter.sv
// Latches kiosk requests, grants one per cycle round-robin when the queue FIFO
// has room, and writes {ticket number, service time} into it.
module ticket_arbiter
  import ticket_arbiter_pkg::*;
#(
  parameter int DT_SZ = DT_SZ_DEF,
  parameter int KIOSK = KIOSK_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  ticket_arbiter_if.slave bus
);

  localparam int PW = (KIOSK > 1) ? $clog2(KIOSK) : 1;

  logic [KIOSK-1:0] pend_q, pend_d;
  logic [DT_SZ-1:0] hold_q [KIOSK];
  logic [DT_SZ-1:0] hold_d [KIOSK];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [DT_SZ-1:0] nxt_q, nxt_d;
  logic             we_q, we_d;
  logic [KIOSK-1:0] ack_q, ack_d;
  logic [KIOSK-1:0] drop_q, drop_d;
  logic [DT_SZ-1:0] wn_q, wn_d;
  logic [DT_SZ-1:0] wt_q, wt_d;

  logic [KIOSK-1:0] gnt;
  logic [PW-1:0]    win;
  logic             win_vld;
  logic             grant;
  logic [DT_SZ-1:0] slice;

  rr_arbiter #(.N(KIOSK)) u_rr (
    .pend (pend_q),
    .ptr  (ptr_q),
    .gnt  (gnt),
    .idx  (win),
    .vld  (win_vld)
  );

  // full is sampled at the granting edge; a write once issued is never retracted.
  assign grant = win_vld && !bus.full;

  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    ptr_d  = ptr_q;
    nxt_d  = nxt_q;
    we_d   = 1'b0;
    ack_d  = '0;
    drop_d = '0;
    wn_d   = wn_q;
    wt_d   = wt_q;
    slice  = '0;

    if (grant) begin
      we_d   = 1'b1;
      ack_d  = gnt;
      wn_d   = nxt_q;
      wt_d   = hold_q[win];
      pend_d = pend_q & ~gnt;
      ptr_d  = (win == PW'(KIOSK - 1)) ? '0 : win + 1'b1;
      nxt_d  = DT_SZ'(next_ticket(32'(nxt_q), DT_SZ));
    end

    // Checked against registered pend, so a kiosk granted at this edge still drops.
    for (int i = 0; i < KIOSK; i++) begin
      slice = bus.rt[i*DT_SZ +: DT_SZ];
      if (bus.req[i]) begin
        if ((slice == '0) || pend_q[i]) begin
          drop_d[i] = 1'b1;
        end else begin
          hold_d[i] = slice;
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      for (int i = 0; i < KIOSK; i++) hold_q[i] <= '0;
      ptr_q  <= '0;
      nxt_q  <= DT_SZ'(TICKET_FIRST);
      we_q   <= 1'b0;
      ack_q  <= '0;
      drop_q <= '0;
      wn_q   <= '0;
      wt_q   <= '0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
      ptr_q  <= ptr_d;
      nxt_q  <= nxt_d;
      we_q   <= we_d;
      ack_q  <= ack_d;
      drop_q <= drop_d;
      wn_q   <= wn_d;
      wt_q   <= wt_d;
    end
  end

  always_comb begin
    if (pend_q == '0)  bus.state = ST_IDLE;
    else if (bus.full) bus.state = ST_STALL;
    else               bus.state = ST_ARB;
  end

  assign bus.we   = we_q;
  assign bus.ack  = ack_q;
  assign bus.drop = drop_q;
  assign bus.wn   = wn_q;
  assign bus.wt   = wt_q;
  assign bus.pend = pend_q;
  assign bus.nxt  = nxt_q;

endmodule

// File: tb/tb_ticket_arbiter.sv
// Directed bench for ticket_arbiter: reset, single request, round-robin,
// back-pressure, drops and ticket wrap, with hand-computed expectations.
module tb_ticket_arbiter;
  import ticket_arbiter_pkg::*;

  localparam int DT_SZ = 4;
  localparam int KIOSK = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [DT_SZ-1:0] exp_q[$];
  logic [DT_SZ-1:0] exp_wn;
  logic [DT_SZ-1:0] model_nxt;

  ticket_arbiter_if #(.DT_SZ(DT_SZ), .KIOSK(KIOSK)) bus ();

  ticket_arbiter #(.DT_SZ(DT_SZ), .KIOSK(KIOSK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [KIOSK-1:0] r, input logic [KIOSK*DT_SZ-1:0] t);
    bus.req = r;
    bus.rt  = t;
  endtask

  task automatic check_write(input string tag, input logic [KIOSK-1:0] a,
                             input logic [DT_SZ-1:0] n, input logic [DT_SZ-1:0] t);
    check({tag, "_we"},  32'(bus.we), 32'd1);
    check({tag, "_ack"}, 32'(bus.ack), 32'(a));
    check({tag, "_wn"},  32'(bus.wn), 32'(n));
    check({tag, "_wt"},  32'(bus.wt), 32'(t));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},   32'(bus.we),   32'd0);
    check({tag, "_ack"},  32'(bus.ack),  32'd0);
    check({tag, "_drop"}, 32'(bus.drop), 32'd0);
    check({tag, "_pend"}, 32'(bus.pend), 32'd0);
    check({tag, "_wn"},   32'(bus.wn),   32'd0);
    check({tag, "_wt"},   32'(bus.wt),   32'd0);
    check({tag, "_nxt"},  32'(bus.nxt),  32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.rt   = '0;
    bus.full = 1'b0;

    // Reset state and release cycle
    repeat (2) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();
    check("rel_we", 32'(bus.we), 32'd0);

    // Single request: kiosk 1, time 5
    drive(3'b010, 12'h050);
    step();
    check("single_pend", 32'(bus.pend), 32'b010);
    check("single_we0", 32'(bus.we), 32'd0);
    drive(3'b000, 12'h000);
    step();
    check_write("single", 3'b010, 4'd1, 4'd5);
    check("single_nxt", 32'(bus.nxt), 32'd2);
    check("single_pend0", 32'(bus.pend), 32'd0);
    step();
    check("single_pulse", 32'(bus.we), 32'd0);
    check("single_wn_hold", 32'(bus.wn), 32'd1);
    check("single_wt_hold", 32'(bus.wt), 32'd5);

    // Reset mid-traffic discards the pending request
    drive(3'b001, 12'h007);
    step();
    check("mid_pend", 32'(bus.pend), 32'b001);
    drive(3'b000, 12'h000);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    step();
    check("midrel_we", 32'(bus.we), 32'd0);
    check("midrel_pend", 32'(bus.pend), 32'd0);

    // Round-robin: all three kiosks at once, times 2,3,4
    drive(3'b111, 12'h432);
    step();
    check("rr_pend", 32'(bus.pend), 32'b111);
    check("rr_state", 32'(bus.state), 32'(ST_ARB));
    drive(3'b000, 12'h000);
    step();
    check_write("rr0", 3'b001, 4'd1, 4'd2);
    step();
    check_write("rr1", 3'b010, 4'd2, 4'd3);
    step();
    check_write("rr2", 3'b100, 4'd3, 4'd4);
    check("rr_pend0", 32'(bus.pend), 32'd0);
    check("rr_state_idle", 32'(bus.state), 32'(ST_IDLE));

    // ptr wrapped to 0: kiosk 0 ahead of kiosk 2
    drive(3'b101, 12'h906);
    step();
    drive(3'b000, 12'h000);
    step();
    check_write("wrap0", 3'b001, 4'd4, 4'd6);
    step();
    check_write("wrap2", 3'b100, 4'd5, 4'd9);

    // Back-pressure: pend=011 held for 4 cycles under full
    bus.full = 1'b1;
    drive(3'b011, 12'h018);
    step();
    drive(3'b000, 12'h000);
    for (int i = 0; i < 4; i++) begin
      check("bp_we", 32'(bus.we), 32'd0);
      check("bp_pend", 32'(bus.pend), 32'b011);
      check("bp_nxt", 32'(bus.nxt), 32'd6);
      check("bp_state", 32'(bus.state), 32'(ST_STALL));
      step();
    end
    check("bp_we_last", 32'(bus.we), 32'd0);
    bus.full = 1'b0;
    step();
    check_write("bp0", 3'b001, 4'd6, 4'd8);
    step();
    check_write("bp1", 3'b010, 4'd7, 4'd1);

    // Drops: duplicate request keeps original time; zero time rejected
    bus.full = 1'b1;
    drive(3'b100, 12'hA00);
    step();
    check("dup_pend", 32'(bus.pend), 32'b100);
    drive(3'b100, 12'h300);
    step();
    check("dup_drop", 32'(bus.drop), 32'b100);
    check("dup_pend_keep", 32'(bus.pend), 32'b100);
    drive(3'b001, 12'h000);
    step();
    check("zero_drop", 32'(bus.drop), 32'b001);
    check("zero_pend", 32'(bus.pend), 32'b100);
    drive(3'b000, 12'h000);
    bus.full = 1'b0;
    step();
    check("drop_pulse", 32'(bus.drop), 32'd0);
    check_write("dup_served", 3'b100, 4'd8, 4'hA);

    // Request on the edge that grants the same kiosk is dropped
    drive(3'b001, 12'h004);
    step();
    drive(3'b001, 12'h00B);
    step();
    check_write("gdrop", 3'b001, 4'd9, 4'd4);
    check("gdrop_drop", 32'(bus.drop), 32'b001);
    check("gdrop_pend", 32'(bus.pend), 32'd0);
    drive(3'b000, 12'h000);

    // Wrap: 16 tickets after a fresh reset run 1..15 then 1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    model_nxt = 4'd1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(model_nxt);
      model_nxt = (model_nxt == 4'd15) ? 4'd1 : model_nxt + 4'd1;
    end
    for (int i = 0; i < 16; i++) begin
      drive(3'b001 << (i % 3), 12'((i % 15) + 1) << (4 * (i % 3)));
      step();
      drive(3'b000, 12'h000);
      step();
      exp_wn = exp_q.pop_front();
      check_write("tk", 3'b001 << (i % 3), exp_wn, 4'((i % 15) + 1));
      check("tk_nonzero", 32'(bus.wn != '0), 32'd1);
    end
    check("tk_nxt", 32'(bus.nxt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ticket_arbiter.md
# ticket_arbiter

Shares the single queue-FIFO write port among several ticket kiosks. Each kiosk posts a request carrying a service time. The block latches the request, arbitrates round-robin among pending kiosks, and assigns a sequential customer number. It then writes {number, time} into the queue FIFO that feeds the counter dispatcher. It is the producer side of the queue; the dispatcher is the consumer side.

## Interface
- DT_SZ, 4, width of customer number and service time (matches queue FIFO / dispatcher)
- KIOSK, 3, number of requesting kiosks (≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  KIOSK  per-kiosk request pulse, sampled at clk rise
- rt  in  KIOSK*DT_SZ  per-kiosk service time; kiosk i uses bits [i*DT_SZ +: DT_SZ], valid while req[i]=1
- full  in  1  queue FIFO full flag
- we  out  1  FIFO write pulse, 1 clk
- wn  out  DT_SZ  customer number written with we
- wt  out  DT_SZ  service time written with we
- ack  out  KIOSK  one-hot pulse, 1 clk, coincident with we; names the kiosk served
- drop  out  KIOSK  pulse, 1 clk; request rejected
- pend  out  KIOSK  pending-request flags, registered
- nxt  out  DT_SZ  next ticket number to be issued

## Operation
- Request capture, per kiosk i, at clk rise with req[i]=1:
  - rt slice = 0 → reject: drop[i]=1, nothing latched.
  - pend[i]=1 at that edge, including the edge that grants i → reject: drop[i]=1, held time unchanged.
  - Otherwise: hold[i] ← rt slice, pend[i] ← 1.
- Arbitration, evaluated every cycle on registered state:
  - Grant only if full=0 and pend≠0.
  - Winner is the first set pend bit starting at pointer ptr, scanning upward with wrap.
  - On grant at an edge:
    - we=1, ack[w]=1, wn=nxt, wt=hold[w], pend[w] ← 0
    - ptr ← (w+1) mod KIOSK
    - nxt ← next ticket
- Ticket sequence: 1, 2, …, 2^DT_SZ−1, then 1 again. Value 0 is never issued; 0 means "no customer" downstream.
- full=1: no grant. pend, ptr and nxt hold. Requests continue to be captured or dropped normally.
- At most one FIFO write per cycle. Several simultaneous req in one cycle are all captured in that cycle.
- Effective state: IDLE (pend=0), ARB (pend≠0, full=0, grants every cycle), STALL (pend≠0, full=1). No further control FSM.

## Timing
- Reset values:
  - we=0, ack=0, drop=0, pend=0, wn=0, wt=0
  - nxt=1, ptr=0, hold=0
- Reset asserted mid-operation discards all pending requests. No write is emitted during reset or in the cycle of release.
- All outputs are registered. we/ack/drop are 1-cycle pulses and default to 0 at every edge.
- Latency: req captured at edge N → earliest we/ack at edge N+1.
- full is sampled at the granting edge. A write issued while full=0 is never retracted.
- wn/wt are valid only with we=1 and hold their last value otherwise.
- Sustained throughput with full=0 is one ticket per clk.

## Structure
- Shared package:
  - DT_SZ default
  - TICKET_FIRST=1 and TICKET_NONE=0
  - ticket-increment function with skip-zero wrap, reused by any block that numbers customers
- Sub-module rr_arbiter, parameter N:
  - inputs pend and ptr; outputs one-hot gnt and binary index
  - combinational masked priority encoder, used as two passes: masked by ptr, then unmasked
- ticket_arbiter owns the request latches, ptr, nxt and output registers.

## Test plan
- Reset: hold rst_n=0 mid-traffic → all outputs 0, nxt=1, pend=0. Release → no we in the first cycle.
- Single request: req[1] with rt slice 5, full=0 → next edge we=1, ack=3'b010, wn=1, wt=5; nxt=2, pend=0.
- Round-robin: req=3'b111 with times 2,3,4 in one cycle → three consecutive writes, kiosks 0,1,2, wn 1,2,3, wt 2,3,4. Then req=3'b101 → kiosk 0 is served before kiosk 2, since ptr wrapped to 0.
- Back-pressure: pend=3'b011, full=1 for 4 cycles → no we, pend holds. full drops → kiosk at ptr served next edge; ticket numbers have no gaps.
- Drops:
  - req[2] while pend[2]=1 → drop=3'b100, original wt kept.
  - req[0] with rt slice 0 → drop=3'b001, pend[0] stays 0.
- Wrap: with DT_SZ=4, issue 16 tickets → wn runs 1…15 then 1; wn is never 0.
